// File: rtl/inst_rom_resp.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom_resp
// Description : Instruction-side memory responder. Returns the 32-bit word
//               at a byte fetch address with one cycle of registered latency,
//               flags misaligned / out-of-range fetches and keeps a saturating
//               count of served fetches. A LOAD mode lets boot logic write
//               the program store. While in LOAD, fetches return the NOP word.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   ce, addr        fetch enable and byte fetch address from the PC stage
//   inst            registered instruction word (RESET_INST when not valid)
//   inst_valid      inst holds a real fetched word
//   fault           0 none, 1 misaligned, 2 out-of-range, 3 parity (option)
//   ld_start/ld_end enter / leave LOAD mode (ld_end wins when both are high)
//   ld_we, ld_addr, ld_data   word write port, active only in LOAD
//   busy            1 while in LOAD
//   fetch_cnt       saturating count of valid fetches
//   par_err_cnt     saturating count of parity faults (option only)
// Optional feature macro: INST_ROM_PARITY_EN (per-word even parity).
// ============================================================================
module inst_rom_resp #(
  parameter int          DEPTH      = 1024,
  parameter int          AW         = 10,
  parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [31:0]   addr,
  output logic [31:0]   inst,
  output logic          inst_valid,
  output logic [1:0]    fault,
  input  logic          ld_start,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_end,
  output logic          busy,
  output logic [15:0]   fetch_cnt
`ifdef INST_ROM_PARITY_EN
  ,
  output logic [7:0]    par_err_cnt
`endif
);

  localparam logic [1:0] c_FAULT_NONE = 2'd0;
  localparam logic [1:0] c_FAULT_MIS  = 2'd1;
  localparam logic [1:0] c_FAULT_OOR  = 2'd2;
`ifdef INST_ROM_PARITY_EN
  localparam logic [1:0] c_FAULT_PAR  = 2'd3;
`endif

  typedef enum logic [0:0] {
    S_SERVE = 1'b0,
    S_LOAD  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_mem [DEPTH];
`ifdef INST_ROM_PARITY_EN
  logic        r_par [DEPTH];
  logic        w_par_bad;
  logic        w_par_hit;
  logic [7:0]  r_par_err_cnt;
`endif

  logic [31:0] r_inst;
  logic        r_inst_valid;
  logic [1:0]  r_fault;
  logic [15:0] r_fetch_cnt;

  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd_word;
  logic          w_fetch;
  logic          w_mis;
  logic          w_oor;
  logic [31:0]   w_inst_nxt;
  logic          w_valid_nxt;
  logic [1:0]    w_fault_nxt;

  // ---------------- mode FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_SERVE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ld_end)        w_state_nxt = S_SERVE;   // ld_end dominates ld_start
    else if (ld_start) w_state_nxt = S_LOAD;
  end

  // ---------------- program store (not reset) ----------------
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && ld_we) begin
      r_mem[ld_addr] <= ld_data;
`ifdef INST_ROM_PARITY_EN
      r_par[ld_addr] <= ^ld_data;                // even parity over the word
`endif
    end
  end

  // ---------------- fetch decode ----------------
  // DEPTH is 2**AW, so any set bit above the word index means out-of-range;
  // this also keeps high addresses such as 32'hFFFF_FFFC from aliasing.
  assign w_idx     = addr[AW+1:2];
  assign w_rd_word = r_mem[w_idx];
  assign w_mis     = |addr[1:0];
  assign w_oor     = |addr[31:AW+2];
  assign w_fetch   = (r_state == S_SERVE) && ce;
`ifdef INST_ROM_PARITY_EN
  assign w_par_bad = (^w_rd_word) != r_par[w_idx];
`endif

  always_comb begin
    w_inst_nxt  = RESET_INST;
    w_valid_nxt = 1'b0;
    w_fault_nxt = c_FAULT_NONE;
`ifdef INST_ROM_PARITY_EN
    w_par_hit   = 1'b0;
`endif
    if (w_fetch) begin
      if (w_mis) begin
        w_fault_nxt = c_FAULT_MIS;
      end else if (w_oor) begin
        w_fault_nxt = c_FAULT_OOR;
`ifdef INST_ROM_PARITY_EN
      end else if (w_par_bad) begin
        w_fault_nxt = c_FAULT_PAR;
        w_par_hit   = 1'b1;
`endif
      end else begin
        w_inst_nxt  = w_rd_word;
        w_valid_nxt = 1'b1;
      end
    end
  end

  // ---------------- response registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst       <= RESET_INST;
      r_inst_valid <= 1'b0;
      r_fault      <= c_FAULT_NONE;
      r_fetch_cnt  <= 16'h0000;
    end else begin
      r_inst       <= w_inst_nxt;
      r_inst_valid <= w_valid_nxt;
      r_fault      <= w_fault_nxt;
      if (w_valid_nxt && (r_fetch_cnt != 16'hFFFF))
        r_fetch_cnt <= r_fetch_cnt + 16'h0001;
    end
  end

`ifdef INST_ROM_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_par_err_cnt <= 8'h00;
    else if (w_par_hit && (r_par_err_cnt != 8'hFF))
      r_par_err_cnt <= r_par_err_cnt + 8'h01;
  end
  assign par_err_cnt = r_par_err_cnt;
`endif

  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign fault      = r_fault;
  assign fetch_cnt  = r_fetch_cnt;
  assign busy       = (r_state == S_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_rom_resp
// Description : Scoreboard bench for inst_rom_resp. Directed stimulus pushes
//               hand-computed responses; a monitor pops and compares them one
//               cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rom_resp;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   inst;
  logic          inst_valid;
  logic [1:0]    fault;
  logic          ld_start = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;
  logic          ld_end = 1'b0;
  logic          busy;
  logic [15:0]   fetch_cnt;
`ifdef INST_ROM_PARITY_EN
  logic [7:0]    par_err_cnt;
`endif

  inst_rom_resp #(.DEPTH(1024), .AW(AW), .RESET_INST(32'h0)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr),
    .inst(inst), .inst_valid(inst_valid), .fault(fault),
    .ld_start(ld_start), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_end(ld_end),
    .busy(busy), .fetch_cnt(fetch_cnt)
`ifdef INST_ROM_PARITY_EN
    , .par_err_cnt(par_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        v;
    logic [1:0]  f;
    logic        b;
    logic [15:0] c;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mcnt = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compares every response that has become due
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        checks++;
        if (inst !== e.inst || inst_valid !== e.v || fault !== e.f ||
            busy !== e.b || fetch_cnt !== e.c) begin
          errors++;
          $display("FAIL resp@%0d: got inst=%h v=%b f=%0d busy=%b cnt=%h expected inst=%h v=%b f=%0d busy=%b cnt=%h",
                   cyc, inst, inst_valid, fault, busy, fetch_cnt,
                   e.inst, e.v, e.f, e.b, e.c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1) and queue its response.
  task automatic step(input logic c_e, input logic [31:0] a,
                      input logic lds, input logic we, input logic [AW-1:0] la,
                      input logic [31:0] ld, input logic lde,
                      input logic [31:0] ei, input logic ev, input logic [1:0] ef,
                      input logic eb);
    exp_t e;
    ce = c_e; addr = a; ld_start = lds; ld_we = we;
    ld_addr = la; ld_data = ld; ld_end = lde;
    if (ev && mcnt != 16'hFFFF) mcnt = mcnt + 16'h1;
    e.inst = ei; e.v = ev; e.f = ef; e.b = eb; e.c = mcnt; e.due = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_cnt", {16'h0, fetch_cnt}, 32'h0);
    rst = 1'b0;

    // idle
    repeat (3) step(0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);

    // load program; write on the ld_end edge must still commit
    step(0, 32'h0, 1, 0, 0, 0,             0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 0, 1, 0, 32'h3401_1100, 0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 0, 1, 1, 32'h3421_0020, 0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 0, 1, 2, 32'h0000_00FF, 1, 32'h0, 0, 0, 0);

    // back-to-back fetches
    step(1, 32'h0, 0, 0, 0, 0, 0, 32'h3401_1100, 1, 0, 0);
    step(1, 32'h4, 0, 0, 0, 0, 0, 32'h3421_0020, 1, 0, 0);
    step(1, 32'h8, 0, 0, 0, 0, 0, 32'h0000_00FF, 1, 0, 0);

    // faults
    step(1, 32'h0000_0006, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
    step(1, 32'h0000_1000, 0, 0, 0, 0, 0, 32'h0, 0, 2, 0);
    step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'h0, 0, 2, 0);
    step(1, 32'h0000_1002, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
    step(0, 32'h0000_0004, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);

    // ld_we in SERVE is ignored
    step(1, 32'h0, 0, 1, 0, 32'hDEAD_BEEF, 0, 32'h3401_1100, 1, 0, 0);
    step(1, 32'h0, 0, 0, 0, 0,             0, 32'h3401_1100, 1, 0, 0);

    // streaming fetch across a load window
    step(1, 32'h4, 0, 0, 0, 0, 0, 32'h3421_0020, 1, 0, 0);
    step(1, 32'h4, 1, 0, 0, 0, 0, 32'h3421_0020, 1, 0, 1);
    step(1, 32'h4, 0, 0, 0, 0, 0, 32'h0,         0, 0, 1);
    step(1, 32'h4, 1, 0, 0, 0, 1, 32'h0,         0, 0, 0);
    step(1, 32'h4, 0, 0, 0, 0, 0, 32'h3421_0020, 1, 0, 0);
    // both pulses high while serving: stays in SERVE
    step(1, 32'h0, 1, 0, 0, 0, 1, 32'h3401_1100, 1, 0, 0);
    step(1, 32'h0, 0, 0, 0, 0, 0, 32'h3401_1100, 1, 0, 0);

    // counter saturation
    for (int i = 0; i < 65540; i++)
      step(1, 32'h0, 0, 0, 0, 0, 0, 32'h3401_1100, 1, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    chk("sat_cnt", {16'h0, fetch_cnt}, 32'h0000_FFFF);

    // asynchronous reset in the middle of a load
    step(0, 32'h0, 1, 0, 0, 0,             0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 0, 1, 3, 32'h1234_5678, 0, 32'h0, 0, 0, 1);
    #2;
    ld_we = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_valid", {31'h0, inst_valid}, 32'h0);
    chk("arst_cnt", {16'h0, fetch_cnt}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mcnt = 16'h0;
    step(1, 32'hC, 0, 0, 0, 0, 0, 32'h1234_5678, 1, 0, 0);
    step(1, 32'h0, 0, 0, 0, 0, 0, 32'h3401_1100, 1, 0, 0);

`ifdef INST_ROM_PARITY_EN
    dut.r_par[2] = ~dut.r_par[2];
    step(1, 32'h8, 0, 0, 0, 0, 0, 32'h0, 0, 3, 0);
    step(0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    chk("par_err_cnt", {24'h0, par_err_cnt}, 32'h1);
    chk("par_fetch_cnt", {16'h0, fetch_cnt}, 32'h2);
`endif

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
